// File: rtl/hdmi_pkg.sv
// Shared constants, mode encodings, bar colours and box-axis helper for the HDMI pattern source.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package hdmi_pkg;

   localparam int H_PIXEL_720P = 1280;
   localparam int V_PIXEL_720P = 720;

   // Pixel coordinates and box positions share one width; wide enough for 720p
   // and for the fixed x[10:3] / y[9:2] gradient slices.
   localparam int COORD_W = 12;

   typedef enum logic [2:0] {
      MODE_SOLID    = 3'd0,
      MODE_SPLIT    = 3'd1,
      MODE_BARS     = 3'd2,
      MODE_CHECKER  = 3'd3,
      MODE_GRADIENT = 3'd4,
      MODE_BOX      = 3'd5
   } mode_e;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } rgb_t;

   // Index 0 is the leftmost bar: white, yellow, cyan, green, magenta, red, blue, black.
   localparam logic [7:0][23:0] BAR_RGB = {
      24'h000000, 24'h0000FF, 24'hFF0000, 24'hFF00FF,
      24'h00FF00, 24'h00FFFF, 24'hFFFF00, 24'hFFFFFF
   };

   typedef struct packed {
      logic [COORD_W-1:0] pos;
      logic               neg;   // 1 = moving toward 0
   } axis_t;

   // One bounce step: reverse and clamp when the next position would leave [0, lim].
   function automatic axis_t axis_next(input logic [COORD_W-1:0] pos, input logic neg,
                                       input logic [COORD_W-1:0] lim, input logic [COORD_W-1:0] stp);
      axis_t r;
      r.pos = pos;
      r.neg = neg;
      if (!neg) begin
         if (({1'b0, pos} + {1'b0, stp}) > {1'b0, lim}) begin
            r.pos = lim;
            r.neg = 1'b1;
         end else begin
            r.pos = pos + stp;
         end
      end else begin
         if (pos < stp) begin
            r.pos = '0;
            r.neg = 1'b0;
         end else begin
            r.pos = pos - stp;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/hdmi_box_mover.sv
// Bouncing-box position/direction registers, one bounce step per frame-start strobe.
// Latency: new position visible the cycle after the step strobe.
// Backpressure: none; steps on every strobe.
module hdmi_box_mover
   import hdmi_pkg::*;
#(
   parameter int H_PIXEL  = H_PIXEL_720P,
   parameter int V_PIXEL  = V_PIXEL_720P,
   parameter int BOX_SIZE = 64,
   parameter int BOX_STEP = 2
) (
   input  logic               pixclk,
   input  logic               reset,
   input  logic               step,
   output logic [COORD_W-1:0] box_x,
   output logic [COORD_W-1:0] box_y
);

   localparam logic [COORD_W-1:0] X_MAX = COORD_W'(H_PIXEL - BOX_SIZE);
   localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(V_PIXEL - BOX_SIZE);
   localparam logic [COORD_W-1:0] STP   = COORD_W'(BOX_STEP);

   logic  dir_x;
   logic  dir_y;
   axis_t nx;
   axis_t ny;

   assign nx = axis_next(box_x, dir_x, X_MAX, STP);
   assign ny = axis_next(box_y, dir_y, Y_MAX, STP);

   // Advance both axes once per frame; box starts at the origin heading +x/+y.
   always_ff @(posedge pixclk or posedge reset) begin
      if (reset) begin
         box_x <= '0;
         box_y <= '0;
         dir_x <= 1'b0;
         dir_y <= 1'b0;
      end else if (step) begin
         box_x <= nx.pos;
         dir_x <= nx.neg;
         box_y <= ny.pos;
         dir_y <= ny.neg;
      end
   end

endmodule

// File: rtl/hdmi_pattern_source.sv
// Test-pattern pixel source: linear active-pixel address in, 24-bit RGB out.
// Latency: 2 cycles addr -> RGB (address tracker, then registered pattern mux).
// Backpressure: none; follows the transceiver address every cycle.
module hdmi_pattern_source
   import hdmi_pkg::*;
#(
   parameter int H_PIXEL  = H_PIXEL_720P,
   parameter int V_PIXEL  = V_PIXEL_720P,
   parameter int ADDR_W   = 21,
   parameter int BAR_W    = H_PIXEL / 8,
   parameter int BOX_SIZE = 64,
   parameter int BOX_STEP = 2
) (
   input  logic              pixclk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] addr,
   input  logic [2:0]        mode_sel,
   input  logic              mode_req,
   output logic [7:0]        red,
   output logic [7:0]        green,
   output logic [7:0]        blue,
   output logic [2:0]        active_mode,
   output logic              frame_start,
   output logic [15:0]       frame_cnt,
   output logic              sync_lost
);

   logic [ADDR_W-1:0]  addr_q;
   logic [COORD_W-1:0] x;
   logic [COORD_W-1:0] y;
   logic [COORD_W-1:0] bar_px;
   logic [2:0]         bar_idx;
   logic [2:0]         pend_mode;
   logic               fs_s1;
   logic               is_start;
   logic               is_next;
   logic [COORD_W-1:0] box_x;
   logic [COORD_W-1:0] box_y;
   rgb_t               pix_next;

   // A return to address 0 from anywhere else opens a new frame.
   assign is_start = (addr == '0) && (addr_q != '0);
   assign is_next  = (addr == (addr_q + ADDR_W'(1)));

   hdmi_box_mover #(
      .H_PIXEL  (H_PIXEL),
      .V_PIXEL  (V_PIXEL),
      .BOX_SIZE (BOX_SIZE),
      .BOX_STEP (BOX_STEP)
   ) u_box (
      .pixclk (pixclk),
      .reset  (reset),
      .step   (is_start),
      .box_x  (box_x),
      .box_y  (box_y)
   );

   // Stage 1: track the address into x/y and bar counters; mode and sync state change only at frame start.
   always_ff @(posedge pixclk or posedge reset) begin
      if (reset) begin
         addr_q      <= '0;
         x           <= '0;
         y           <= '0;
         bar_px      <= '0;
         bar_idx     <= '0;
         pend_mode   <= '0;
         active_mode <= '0;
         frame_cnt   <= '0;
         sync_lost   <= 1'b0;
         fs_s1       <= 1'b0;
      end else begin
         addr_q <= addr;
         fs_s1  <= is_start;
         if (mode_req) pend_mode <= mode_sel;
         if (is_start) begin
            x           <= '0;
            y           <= '0;
            bar_px      <= '0;
            bar_idx     <= '0;
            sync_lost   <= 1'b0;
            frame_cnt   <= frame_cnt + 16'd1;
            active_mode <= mode_req ? mode_sel : pend_mode;
         end else if (addr != addr_q) begin
            if (!is_next) begin
               // Discontinuity: freeze the pixel until the next frame start.
               sync_lost <= 1'b1;
            end else if (!sync_lost) begin
               if (x == COORD_W'(H_PIXEL - 1)) begin
                  x       <= '0;
                  y       <= y + COORD_W'(1);
                  bar_px  <= '0;
                  bar_idx <= '0;
               end else begin
                  x <= x + COORD_W'(1);
                  if (bar_px == COORD_W'(BAR_W - 1)) begin
                     bar_px  <= '0;
                     bar_idx <= bar_idx + 3'd1;
                  end else begin
                     bar_px <= bar_px + COORD_W'(1);
                  end
               end
            end
         end
      end
   end

   // Stage 2 select: colour of the tracked pixel under the active mode.
   always_comb begin
      pix_next = '0;
      case (mode_e'(active_mode))
         MODE_SOLID:    pix_next = 24'hFF0000;
         MODE_SPLIT:    pix_next = (y < COORD_W'(V_PIXEL / 2)) ? 24'hFF0000 : 24'h0000FF;
         MODE_BARS:     pix_next = BAR_RGB[bar_idx];
         MODE_CHECKER:  pix_next = (x[5] ^ y[5]) ? 24'hFFFFFF : 24'h000000;
         MODE_GRADIENT: pix_next = {x[10:3], y[9:2], frame_cnt[7:0]};
         MODE_BOX:      pix_next = ((x >= box_x) && (x < box_x + COORD_W'(BOX_SIZE)) &&
                                    (y >= box_y) && (y < box_y + COORD_W'(BOX_SIZE)))
                                   ? 24'hFFFFFF : 24'h000000;
         default:       pix_next = '0;
      endcase
   end

   // Stage 2 register: RGB and the frame_start pulse aligned to pixel 0.
   always_ff @(posedge pixclk or posedge reset) begin
      if (reset) begin
         red         <= '0;
         green       <= '0;
         blue        <= '0;
         frame_start <= 1'b0;
      end else begin
         red         <= pix_next.r;
         green       <= pix_next.g;
         blue        <= pix_next.b;
         frame_start <= fs_s1;
      end
   end

endmodule
